// File: rtl/lag_pl_input_trunk_credit_if.sv
// lag_pl_input_trunk_credit_if: link-receiver / allocator bundle for one input port's PL trunk.
interface lag_pl_input_trunk_credit_if #(
  parameter int NUM_PLS = 4,
  parameter int BUF_DEPTH = 8,
  parameter int DATA_W = 64
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  logic [NUM_PLS-1:0] push, tail_in, pop, pl_new_valid;
  logic [NUM_PLS*DATA_W-1:0] data_in, data_out;
  logic [NUM_PLS-1:0] tail_out, empty, full, nearly_full;
  logic [NUM_PLS*CNT_W-1:0] occupancy;
  logic [NUM_PLS*NUM_PLS-1:0] pl_new, allocated_pl;
  logic [NUM_PLS-1:0] allocated_pl_valid, credit_out, err_overflow, err_underflow, err_alloc;
  modport master (
    output push, data_in, tail_in, pop, pl_new, pl_new_valid,
    input data_out, tail_out, empty, full, nearly_full, occupancy, allocated_pl,
    allocated_pl_valid, credit_out, err_overflow, err_underflow, err_alloc
  );
  modport slave (
    input push, data_in, tail_in, pop, pl_new, pl_new_valid,
    output data_out, tail_out, empty, full, nearly_full, occupancy, allocated_pl,
    allocated_pl_valid, credit_out, err_overflow, err_underflow, err_alloc
  );
endinterface

// File: rtl/lag_pl_input_trunk_credit.sv
// lag_pl_input_trunk_credit: per-PL flit FIFOs, output-PL allocation register, credits and sticky errors.
// Define LAG_PL_ALLOC_BYPASS_EN to forward a same-cycle grant straight onto allocated_pl.
module lag_pl_input_trunk_credit #(
  parameter int NUM_PLS = 4,
  parameter int BUF_DEPTH = 8,
  parameter int DATA_W = 64
) (
  input logic clk,
  input logic rst,
  lag_pl_input_trunk_credit_if.slave tr
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH);
  for (genvar p = 0; p < NUM_PLS; p++) begin : g_pl
    logic [DATA_W:0] mem_q [BUF_DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [NUM_PLS-1:0] apl_q, nw;
    logic [DATA_W:0] head;
    logic av_q, cr_q, eo_q, eu_q, ea_q;
    logic emp, ful, do_pop, do_push, tail_pop, held, bad_grant;
    assign nw = tr.pl_new[p*NUM_PLS +: NUM_PLS];
    assign emp = cnt_q == '0;
    assign ful = cnt_q == CNT_W'(BUF_DEPTH);
    assign do_pop = tr.pop[p] & ~emp;
    assign do_push = tr.push[p] & (~ful | do_pop);
    assign head = emp ? '0 : mem_q[rd_q];
    assign tail_pop = do_pop & head[DATA_W];
    assign bad_grant = tr.pl_new_valid[p] & ((nw == '0) | ((nw & (nw - NUM_PLS'(1))) != '0) | (av_q & ~tail_pop));
`ifdef LAG_PL_ALLOC_BYPASS_EN
    assign held = av_q | tr.pl_new_valid[p];
    assign tr.allocated_pl[p*NUM_PLS +: NUM_PLS] = tr.pl_new_valid[p] ? nw : apl_q;
    assign tr.allocated_pl_valid[p] = held;
`else
    assign held = av_q;
    assign tr.allocated_pl[p*NUM_PLS +: NUM_PLS] = apl_q;
    assign tr.allocated_pl_valid[p] = av_q;
`endif
    assign tr.data_out[p*DATA_W +: DATA_W] = head[DATA_W-1:0];
    assign tr.tail_out[p] = head[DATA_W];
    assign tr.empty[p] = emp;
    assign tr.full[p] = ful;
    assign tr.nearly_full[p] = cnt_q >= CNT_W'(BUF_DEPTH - 1);
    assign tr.occupancy[p*CNT_W +: CNT_W] = cnt_q;
    assign tr.credit_out[p] = cr_q;
    assign tr.err_overflow[p] = eo_q;
    assign tr.err_underflow[p] = eu_q;
    assign tr.err_alloc[p] = ea_q;
    always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= {tr.tail_in[p], tr.data_in[p*DATA_W +: DATA_W]};
    // A tail pop releases the held PL and wins over any coincident grant.
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        rd_q <= '0;
        wr_q <= '0;
        cnt_q <= '0;
        apl_q <= '0;
        av_q <= 1'b0;
        cr_q <= 1'b0;
        eo_q <= 1'b0;
        eu_q <= 1'b0;
        ea_q <= 1'b0;
      end else begin
        rd_q <= rd_q + PW'(do_pop);
        wr_q <= wr_q + PW'(do_push);
        cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        cr_q <= do_pop;
        eo_q <= eo_q | (tr.push[p] & ~do_push);
        eu_q <= eu_q | (tr.pop[p] & emp);
        ea_q <= ea_q | bad_grant | (do_pop & ~held);
        if (tail_pop) begin
          av_q <= 1'b0;
          apl_q <= '0;
        end else if (tr.pl_new_valid[p]) begin
          av_q <= 1'b1;
          apl_q <= nw;
        end
      end
  end
endmodule
